// File: rtl/key_pkg.sv
// Shared types and board defaults for the push-button input conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    // Defaults for the 100 MHz board clock.
    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_input_if.sv
// Key pins and per-key event outputs of the input conditioner, one bit per key.
interface key_input_if #(
    parameter int NKEYS = 2
);

    logic [NKEYS-1:0] key;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic [NKEYS-1:0] key_rpt;

    // Board side: drives the raw pins and consumes the events.
    modport master (
        output key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_rpt
    );

    // Conditioner side.
    modport slave (
        input  key,
        output key_level,
        output key_press,
        output key_release,
        output key_rpt
    );

endinterface

// File: rtl/key_chan.sv
// One key: 2-flop synchroniser, debounce counter and press/release FSM.
// Auto-repeat (HELD -> REPEAT) is compiled in only when KEY_REPEAT_EN is defined.
module key_chan
    import key_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk_in,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("key_chan: DEB_CYCLES must be at least 2");
    end

`ifdef KEY_REPEAT_EN
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_rpt
        $error("key_chan: HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
    end
`else
    if (HOLD_CYCLES < 0 || REPEAT_CYCLES < 0) begin : g_bad_rpt
        $error("key_chan: HOLD_CYCLES and REPEAT_CYCLES must not be negative");
    end
`endif

    localparam int             DW      = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0]  DC_LAST = DW'(DEB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser; reset parks both flops at the released pin level.
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic pressed;

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of statement order.
        if (rst) begin
            sync1_q <= KEY_ACTIVE_LOW;
            sync2_q <= KEY_ACTIVE_LOW;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce: accept a level change after DEB_CYCLES consecutive samples.
    // ------------------------------------------------------------------
    logic          deb_q, deb_d;
    logic [DW-1:0] dc_q, dc_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        deb_d = deb_q;
        dc_d  = '0;
        if (pressed != deb_q) begin
            if (dc_q == DC_LAST) begin
                deb_d = pressed;
            end else begin
                dc_d = dc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            deb_q <= 1'b0;
            dc_q  <= '0;
        end else begin
            deb_q <= deb_d;
            dc_q  <= dc_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FSM; all outputs are registered here.
    // ------------------------------------------------------------------
    key_state_e state_q, state_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;

`ifdef KEY_REPEAT_EN
    localparam int             HW        = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  RPT_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hc_q, hc_d;
    logic          rpt_q, rpt_d;
`endif

    always_comb begin
        state_d = state_q;
        level_d = deb_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_d   = 1'b0;
        hc_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (deb_q) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end
            end
            HELD: begin
                // Release is checked first so it wins over a coincident repeat.
                if (!deb_q) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                else if (hc_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    press_d = 1'b1;
                    rpt_d   = 1'b1;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
`endif
            end
`ifdef KEY_REPEAT_EN
            REPEAT: begin
                if (!deb_q) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else if (hc_q == RPT_LAST) begin
                    press_d = 1'b1;
                    rpt_d   = 1'b1;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hc_q  <= '0;
            rpt_q <= 1'b0;
        end else begin
            hc_q  <= hc_d;
            rpt_q <= rpt_d;
        end
    end

    assign rpt_o = rpt_q;
`else
    assign rpt_o = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/key_input.sv
// Push-button input conditioner: NKEYS independent synchronise/debounce/event channels.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
module key_input
    import key_pkg::*;
#(
    parameter int NKEYS          = 2,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst,
    key_input_if.slave   bus
);

    logic [NKEYS-1:0] level;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] rel;
    logic [NKEYS-1:0] rpt;

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_chan #(
            .DEB_CYCLES     (DEB_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_chan (
            .clk_in    (clk_in),
            .rst       (rst),
            .key_i     (bus.key[i]),
            .level_o   (level[i]),
            .press_o   (press[i]),
            .release_o (rel[i]),
            .rpt_o     (rpt[i])
        );
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = rel;
    assign bus.key_rpt     = rpt;

endmodule

// File: tb/tb_key_input.sv
// Scoreboard bench for key_input: stimulus queues timed expected events, a monitor
// compares every output pulse. Expectations follow KEY_REPEAT_EN when it is defined.
module tb_key_input;
    import key_pkg::*;

    localparam int NK   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;
    localparam int LAT  = DEB + 3;  // drive at negedge c -> event visible at cycle c+LAT

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;

    key_input_if #(.NKEYS(NK)) bus ();

    key_input #(
        .NKEYS          (NK),
        .DEB_CYCLES     (DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (RPT),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rpt;
        logic [NK-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_evt(input int c, input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                              input logic [NK-1:0] rp, input logic [NK-1:0] lv);
        exp_t e;
        e.cyc   = c;
        e.press = pr;
        e.rel   = rl;
        e.rpt   = rp;
        e.level = lv;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   int'(bus.key_level),   0);
        check({tag, "_press"},   int'(bus.key_press),   0);
        check({tag, "_release"}, int'(bus.key_release), 0);
        check({tag, "_rpt"},     int'(bus.key_rpt),     0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if ((bus.key_press | bus.key_release | bus.key_rpt) != '0) begin
            check("event_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("evt_cycle",   cyc,                   e.cyc);
                check("evt_press",   int'(bus.key_press),   int'(e.press));
                check("evt_release", int'(bus.key_release), int'(e.rel));
                check("evt_rpt",     int'(bus.key_rpt),     int'(e.rpt));
                check("evt_level",   int'(bus.key_level),   int'(e.level));
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_event_cycle", cyc, e.cyc);
        end
    end

    initial begin
        int c;
        bus.key = '1;
        rst     = 1'b1;
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(3);

        // Single press and release on key 0.
        step(1);
        c = cyc;
        bus.key[0] = 1'b0;
        expect_evt(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        step(10);
        check("s1_level_held", int'(bus.key_level), 1);
        step(5);
        c = cyc;
        bus.key[0] = 1'b1;
        expect_evt(c + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        step(12);

        // Three-cycle glitches on key 1 are rejected.
        for (int g = 0; g < 3; g++) begin
            step(1);
            bus.key[1] = 1'b0;
            step(3);
            bus.key[1] = 1'b1;
            step(4);
        end
        step(6);
        check("s2_glitch_level", int'(bus.key_level), 0);

        // Exactly DEB_CYCLES low is accepted; release follows 4 cycles later.
        step(1);
        c = cyc;
        bus.key[1] = 1'b0;
        expect_evt(c + LAT,     2'b10, 2'b00, 2'b00, 2'b10);
        step(4);
        bus.key[1] = 1'b1;
        expect_evt(c + 4 + LAT, 2'b00, 2'b10, 2'b00, 2'b00);
        step(15);

        // Ten-cycle press on key 1.
        step(1);
        c = cyc;
        bus.key[1] = 1'b0;
        expect_evt(c + LAT, 2'b10, 2'b00, 2'b00, 2'b10);
        step(10);
        c = cyc;
        bus.key[1] = 1'b1;
        expect_evt(c + LAT, 2'b00, 2'b10, 2'b00, 2'b00);
        step(12);

        // Long hold on key 0: repeats at +20, +28, ... when enabled.
        step(1);
        c = cyc;
        bus.key[0] = 1'b0;
        expect_evt(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef KEY_REPEAT_EN
        for (int k = 0; k < 6; k++) begin
            expect_evt(c + LAT + HOLD + k * RPT, 2'b01, 2'b00, 2'b01, 2'b01);
        end
`endif
        step(62);
        bus.key[0] = 1'b1;
        expect_evt(c + 62 + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        step(15);
        check("s3_rpt_idle", int'(bus.key_rpt), 0);

        // Release accepted on the cycle the first repeat would fire.
        step(1);
        c = cyc;
        bus.key[0] = 1'b0;
        expect_evt(c + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        step(HOLD);
        bus.key[0] = 1'b1;
        expect_evt(c + HOLD + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        step(20);

        // Both keys together, then reset mid-hold with keys still down.
        step(1);
        c = cyc;
        bus.key = 2'b00;
        expect_evt(c + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        step(12);
        check("s5_level_both", int'(bus.key_level), 3);
        rst = 1'b1;
        step(1);
        check_all_zero("s5_reset");
        step(1);
        rst = 1'b0;
        c = cyc;
        expect_evt(c + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        step(10);
        c = cyc;
        bus.key = 2'b11;
        expect_evt(c + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        step(12);

        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
